titan_lsu: RTL and testbench

Load/store unit between the MEM pipeline stage and the data-side Wishbone B4 (classic) bus. Takes the MEM stage's effective address, store data and access-size flags, and runs one single-beat bus cycle. Returns aligned, sign- or zero-extended load data plus a bus-error indication to the MEM stage. Stalls the pipeline while the access is outstanding.

---
 rtl/titan_lsu_pkg.sv | 38 +++
 rtl/titan_lsu_align.sv | 47 ++++
 rtl/titan_lsu.sv | 132 +++++++++++++
 tb/tb_titan_lsu.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/titan_lsu_pkg.sv
// Shared LSU definitions: FSM state encodings, byte-lane constants and the
// access-size flag positions agreed with the MEM stage.
package titan_lsu_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_BUSY = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_e;

    localparam logic [3:0] SEL_WORD   = 4'b1111;
    localparam logic [3:0] SEL_HW_LO  = 4'b0011;
    localparam logic [3:0] SEL_HW_HI  = 4'b1100;
    localparam logic [3:0] SEL_BYTE0  = 4'b0001;

    localparam int unsigned MFLAG_BYTE = 0;
    localparam int unsigned MFLAG_HW   = 1;
    localparam int unsigned MFLAG_WORD = 2;

    // Widest flag wins; no flag at all is treated as a word access.
    function automatic lsu_size_e decode_size(input logic [2:0] flags);
        if (flags[MFLAG_WORD])      return SZ_WORD;
        else if (flags[MFLAG_HW])   return SZ_HALF;
        else if (flags[MFLAG_BYTE]) return SZ_BYTE;
        else                        return SZ_WORD;
    endfunction

    function automatic logic is_misaligned(input lsu_size_e sz, input logic [1:0] lo);
        return ((sz == SZ_WORD) && (lo != 2'b00)) || ((sz == SZ_HALF) && lo[0]);
    endfunction

endpackage

// File: rtl/titan_lsu_align.sv
// Byte-lane steering: store select/data replication and load extraction
// with sign or zero extension.
module titan_lsu_align
    import titan_lsu_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_sel,
    output logic [31:0] st_dat,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_addr_lo,
    input  logic        ld_unsigned,
    input  logic [31:0] bus_dat,
    output logic [31:0] ld_data
);

    logic [31:0] lane;

    always_comb begin
        st_sel = SEL_WORD;
        st_dat = st_wdata;
        case (lsu_size_e'(st_size))
            SZ_HALF: begin
                st_sel = st_addr_lo[1] ? SEL_HW_HI : SEL_HW_LO;
                st_dat = {2{st_wdata[15:0]}};
            end
            SZ_BYTE: begin
                st_sel = SEL_BYTE0 << st_addr_lo;
                st_dat = {4{st_wdata[7:0]}};
            end
            default: ;
        endcase
    end

    // Shift the addressed lane down to bit 0, then extend.
    always_comb begin
        lane    = bus_dat >> {ld_addr_lo, 3'b000};
        ld_data = lane;
        case (lsu_size_e'(ld_size))
            SZ_HALF: ld_data = {{16{~ld_unsigned & lane[15]}}, lane[15:0]};
            SZ_BYTE: ld_data = {{24{~ld_unsigned & lane[7]}}, lane[7:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/titan_lsu.sv
// Load/store unit: one single-beat Wishbone classic cycle per MEM-stage
// access, stalling the pipeline until ack, error or timeout.
module titan_lsu
    import titan_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic        lsu_mread_i,
    input  logic        lsu_mwrite_i,
    input  logic        lsu_mword_i,
    input  logic        lsu_mhw_i,
    input  logic        lsu_mbyte_i,
    input  logic        lsu_munsigned_i,
    input  logic        lsu_kill_i,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_err_o,
    output logic        lsu_stall_o,
    output logic [31:0] dwbm_addr_o,
    output logic [31:0] dwbm_dat_o,
    output logic [3:0]  dwbm_sel_o,
    output logic        dwbm_we_o,
    output logic        dwbm_cyc_o,
    output logic        dwbm_stb_o,
    input  logic [31:0] dwbm_dat_i,
    input  logic        dwbm_ack_i,
    input  logic        dwbm_err_i
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    lsu_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             timeout;
    logic             ld_pend;
    logic [1:0]       ld_size;
    logic [1:0]       ld_lo;
    logic             ld_uns;

    lsu_size_e        size;
    logic             req;
    logic [3:0]       st_sel;
    logic [31:0]      st_dat;
    logic [31:0]      ld_data;

    assign size    = decode_size({lsu_mword_i, lsu_mhw_i, lsu_mbyte_i});
    assign req     = (lsu_mread_i | lsu_mwrite_i) & ~lsu_kill_i
                   & ~is_misaligned(size, lsu_addr_i[1:0]);
    assign cnt_inc = cnt + CNT_W'(1);
    assign timeout = (cnt_inc == CNT_W'(TIMEOUT));

    assign lsu_stall_o = ((state == LSU_IDLE) & req) | (state == LSU_BUSY);

    titan_lsu_align u_align (
        .st_size     (size),
        .st_addr_lo  (lsu_addr_i[1:0]),
        .st_wdata    (lsu_wdata_i),
        .st_sel      (st_sel),
        .st_dat      (st_dat),
        .ld_size     (ld_size),
        .ld_addr_lo  (ld_lo),
        .ld_unsigned (ld_uns),
        .bus_dat     (dwbm_dat_i),
        .ld_data     (ld_data)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= LSU_IDLE;
            cnt         <= '0;
            ld_pend     <= 1'b0;
            ld_size     <= 2'b00;
            ld_lo       <= 2'b00;
            ld_uns      <= 1'b0;
            lsu_rdata_o <= '0;
            lsu_err_o   <= 1'b0;
            dwbm_addr_o <= '0;
            dwbm_dat_o  <= '0;
            dwbm_sel_o  <= '0;
            dwbm_we_o   <= 1'b0;
            dwbm_cyc_o  <= 1'b0;
            dwbm_stb_o  <= 1'b0;
        end else begin
            case (state)
                LSU_IDLE: begin
                    if (req) begin
                        dwbm_addr_o <= {lsu_addr_i[31:2], 2'b00};
                        dwbm_sel_o  <= st_sel;
                        dwbm_dat_o  <= st_dat;
                        dwbm_we_o   <= lsu_mwrite_i;
                        dwbm_cyc_o  <= 1'b1;
                        dwbm_stb_o  <= 1'b1;
                        cnt         <= '0;
                        ld_pend     <= lsu_mread_i & ~lsu_mwrite_i;
                        ld_size     <= size;
                        ld_lo       <= lsu_addr_i[1:0];
                        ld_uns      <= lsu_munsigned_i;
                        state       <= LSU_BUSY;
                    end
                end
                LSU_BUSY: begin
                    cnt <= cnt_inc;
                    // Error beats a simultaneous ack; timeout only fires without ack.
                    if (dwbm_err_i || (!dwbm_ack_i && timeout)) begin
                        dwbm_cyc_o  <= 1'b0;
                        dwbm_stb_o  <= 1'b0;
                        lsu_err_o   <= 1'b1;
                        lsu_rdata_o <= '0;
                        state       <= LSU_DONE;
                    end else if (dwbm_ack_i) begin
                        dwbm_cyc_o <= 1'b0;
                        dwbm_stb_o <= 1'b0;
                        if (ld_pend) begin
                            lsu_rdata_o <= ld_data;
                        end
                        state <= LSU_DONE;
                    end
                end
                LSU_DONE: begin
                    lsu_err_o <= 1'b0;
                    state     <= LSU_IDLE;
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_titan_lsu.sv
// Randomized self-checking bench for titan_lsu with a transaction-level
// reference model and a scripted Wishbone responder.
module tb_titan_lsu;

    localparam int unsigned TO = 4;
    localparam int RESP_ACK  = 0;
    localparam int RESP_ERR  = 1;
    localparam int RESP_NONE = 2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] lsu_addr_i, lsu_wdata_i;
    logic        lsu_mread_i, lsu_mwrite_i, lsu_mword_i, lsu_mhw_i, lsu_mbyte_i;
    logic        lsu_munsigned_i, lsu_kill_i;
    logic [31:0] lsu_rdata_o;
    logic        lsu_err_o, lsu_stall_o;
    logic [31:0] dwbm_addr_o, dwbm_dat_o;
    logic [3:0]  dwbm_sel_o;
    logic        dwbm_we_o, dwbm_cyc_o, dwbm_stb_o;
    logic [31:0] dwbm_dat_i;
    logic        dwbm_ack_i, dwbm_err_i;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] ref_rdata;

    always #5 clk_i = ~clk_i;

    titan_lsu #(.TIMEOUT(TO)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .lsu_addr_i      (lsu_addr_i),
        .lsu_wdata_i     (lsu_wdata_i),
        .lsu_mread_i     (lsu_mread_i),
        .lsu_mwrite_i    (lsu_mwrite_i),
        .lsu_mword_i     (lsu_mword_i),
        .lsu_mhw_i       (lsu_mhw_i),
        .lsu_mbyte_i     (lsu_mbyte_i),
        .lsu_munsigned_i (lsu_munsigned_i),
        .lsu_kill_i      (lsu_kill_i),
        .lsu_rdata_o     (lsu_rdata_o),
        .lsu_err_o       (lsu_err_o),
        .lsu_stall_o     (lsu_stall_o),
        .dwbm_addr_o     (dwbm_addr_o),
        .dwbm_dat_o      (dwbm_dat_o),
        .dwbm_sel_o      (dwbm_sel_o),
        .dwbm_we_o       (dwbm_we_o),
        .dwbm_cyc_o      (dwbm_cyc_o),
        .dwbm_stb_o      (dwbm_stb_o),
        .dwbm_dat_i      (dwbm_dat_i),
        .dwbm_ack_i      (dwbm_ack_i),
        .dwbm_err_i      (dwbm_err_i)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        lsu_mread_i = 0; lsu_mwrite_i = 0; lsu_kill_i = 0;
        lsu_mword_i = 0; lsu_mhw_i = 0; lsu_mbyte_i = 0; lsu_munsigned_i = 0;
    endtask

    // One MEM-stage access; entered and left at posedge+1 with the DUT idle.
    task automatic access(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic rd, input logic wr, input int size,
                          input logic uns, input logic kill, input int waits,
                          input int resp, input logic both, input logic [31:0] bus_rdata);
        int          nbytes, busy, exp_busy;
        logic        misal, req, stall_ok, e_err;
        logic [3:0]  e_sel;
        logic [31:0] e_dat, lane, e_ld;
        nbytes = (size == 0) ? 1 : (size == 1) ? 2 : 4;
        misal  = (int'(addr[1:0]) % nbytes) != 0;
        req    = (rd | wr) & !kill & !misal;
        lsu_addr_i = addr; lsu_wdata_i = wdata;
        lsu_mread_i = rd; lsu_mwrite_i = wr; lsu_kill_i = kill; lsu_munsigned_i = uns;
        lsu_mbyte_i = (size == 0); lsu_mhw_i = (size == 1); lsu_mword_i = (size == 2);
        #1;
        chk("idle_stall", 32'(lsu_stall_o), 32'(req));
        if (!req) begin
            @(posedge clk_i); #1;
            chk("nocyc", 32'(dwbm_cyc_o), 0);
            chk("noerr", 32'(lsu_err_o), 0);
            chk("rdata_hold", lsu_rdata_o, ref_rdata);
            clear_inputs();
            return;
        end
        e_sel = 4'(((1 << nbytes) - 1) << addr[1:0]);
        e_dat = (nbytes == 4) ? wdata :
                (nbytes == 2) ? (wdata & 32'hFFFF) * 32'h0001_0001 :
                                (wdata & 32'hFF) * 32'h0101_0101;
        lane = bus_rdata >> (8 * int'(addr[1:0]));
        e_ld = lane;
        if (nbytes == 1) begin
            e_ld = lane & 32'hFF;
            if (!uns && e_ld >= 32'h80) e_ld = e_ld | 32'hFFFF_FF00;
        end else if (nbytes == 2) begin
            e_ld = lane & 32'hFFFF;
            if (!uns && e_ld >= 32'h8000) e_ld = e_ld | 32'hFFFF_0000;
        end
        @(posedge clk_i); #1;
        chk("addr", dwbm_addr_o, addr & ~32'd3);
        chk("sel", 32'(dwbm_sel_o), 32'(e_sel));
        if (wr) chk("dat", dwbm_dat_o, e_dat);
        chk("we", 32'(dwbm_we_o), 32'(wr));
        chk("cyc_stb", {30'd0, dwbm_cyc_o, dwbm_stb_o}, 32'd3);
        busy = 0; stall_ok = 1;
        dwbm_dat_i = bus_rdata;
        while (dwbm_cyc_o && busy < 40) begin
            stall_ok = stall_ok & lsu_stall_o & dwbm_stb_o;
            dwbm_ack_i = (busy == waits) && (resp == RESP_ACK || (resp == RESP_ERR && both));
            dwbm_err_i = (busy == waits) && (resp == RESP_ERR);
            @(posedge clk_i); #1;
            dwbm_ack_i = 0; dwbm_err_i = 0;
            busy++;
        end
        exp_busy = (resp == RESP_NONE) ? int'(TO) : waits + 1;
        e_err = (resp != RESP_ACK);
        if (e_err) ref_rdata = 0;
        else if (rd && !wr) ref_rdata = e_ld;
        chk("busy_cycles", busy, exp_busy);
        chk("busy_stall", 32'(stall_ok), 1);
        chk("done_err", 32'(lsu_err_o), 32'(e_err));
        chk("done_rdata", lsu_rdata_o, ref_rdata);
        chk("done_stall", 32'(lsu_stall_o), 0);
        clear_inputs();
        @(posedge clk_i); #1;
        chk("err_clear", 32'(lsu_err_o), 0);
        chk("rdata_keep", lsu_rdata_o, ref_rdata);
    endtask

    initial begin
        int size, op, rsel, nb;
        logic [31:0] a;
        rst_i = 1; clear_inputs();
        lsu_addr_i = 0; lsu_wdata_i = 0;
        dwbm_dat_i = 0; dwbm_ack_i = 0; dwbm_err_i = 0;
        ref_rdata = 0;
        #12;
        chk("rst_cyc", {29'd0, dwbm_cyc_o, dwbm_stb_o, dwbm_we_o}, 0);
        chk("rst_sel", 32'(dwbm_sel_o), 0);
        chk("rst_addr", dwbm_addr_o, 0);
        chk("rst_dat", dwbm_dat_o, 0);
        chk("rst_rdata", lsu_rdata_o, 0);
        chk("rst_err_stall", {30'd0, lsu_err_o, lsu_stall_o}, 0);
        #5 rst_i = 0;
        @(posedge clk_i); #1;

        access(32'h100, 0, 1, 0, 2, 0, 0, 2, RESP_ACK, 0, 32'hDEAD_BEEF);
        chk("word_load", lsu_rdata_o, 32'hDEAD_BEEF);
        access(32'h103, 0, 1, 0, 0, 0, 0, 0, RESP_ACK, 0, 32'h8012_3456);
        chk("sbyte_load", lsu_rdata_o, 32'hFFFF_FF80);
        access(32'h103, 0, 1, 0, 0, 1, 0, 0, RESP_ACK, 0, 32'h8012_3456);
        chk("ubyte_load", lsu_rdata_o, 32'h0000_0080);
        access(32'h202, 32'h1234, 0, 1, 1, 0, 0, 0, RESP_ACK, 0, 0);
        access(32'h300, 0, 1, 0, 2, 0, 0, 1, RESP_ERR, 0, 32'h1111_2222);
        access(32'h304, 0, 1, 0, 2, 0, 0, 0, RESP_ERR, 1, 32'h3333_4444);
        access(32'h400, 0, 1, 0, 2, 0, 0, 0, RESP_NONE, 0, 32'h5555_6666);
        access(32'h102, 0, 1, 0, 2, 0, 0, 0, RESP_ACK, 0, 0);
        access(32'h101, 0, 1, 0, 1, 0, 0, 0, RESP_ACK, 0, 0);
        access(32'h100, 0, 1, 0, 2, 0, 1, 0, RESP_ACK, 0, 0);

        // Reset in the middle of a bus cycle, then a clean load.
        lsu_addr_i = 32'h500; lsu_mread_i = 1; lsu_mword_i = 1;
        @(posedge clk_i); #1;
        chk("pre_rst_cyc", 32'(dwbm_cyc_o), 1);
        #2 rst_i = 1; clear_inputs();
        #1;
        chk("async_rst_bus", {29'd0, dwbm_cyc_o, dwbm_stb_o, lsu_stall_o}, 0);
        ref_rdata = 0;
        @(negedge clk_i); rst_i = 0;
        @(posedge clk_i); #1;
        access(32'h600, 0, 1, 0, 2, 0, 0, 1, RESP_ACK, 0, 32'hCAFE_F00D);
        chk("post_rst_load", lsu_rdata_o, 32'hCAFE_F00D);

        for (int i = 0; i < 300; i++) begin
            size = $urandom_range(0, 2);
            nb   = (size == 0) ? 1 : (size == 1) ? 2 : 4;
            a    = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~(32'(nb) - 32'd1);
            op   = $urandom_range(0, 5);
            rsel = $urandom_range(0, 9);
            access(a, $urandom, (op <= 2) || (op == 5), op >= 3, size,
                   1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0,
                   $urandom_range(0, 3),
                   (rsel <= 6) ? RESP_ACK : (rsel <= 8) ? RESP_ERR : RESP_NONE,
                   1'($urandom_range(0, 1)), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
